// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - state encoding and counter sizing shared by the reset sequencer
package rst_seq_pkg;

   typedef enum logic [2:0] {
      HOLD      = 3'd0,
      WAIT_LOCK = 3'd1,
      RELEASE   = 3'd2,
      RUN       = 3'd3,
      ASSERT    = 3'd4
   } state_t;

   // Wide enough for the longest hold, filter or full stagger span without wrapping.
   function automatic int cnt_width(input int por, input int lf, input int stag, input int nch);
      int m;
      m = por;
      if (lf > m) m = lf;
      if (stag * nch > m) m = stag * nch;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser with asynchronous active-low clear to 0
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - lock-qualified power-on sequencer releasing NUM_CH reset domains in staggered order
module rst_sequencer
   import rst_seq_pkg::*;
#(
   parameter int NUM_CH         = 3,
   parameter int POR_CYCLES     = 3,
   parameter int USE_LOCK       = 1,
   parameter int LOCK_FILTER    = 8,
   parameter int STAGGER_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pll_lock,
   input  logic              soft_rst_req,
   output logic [NUM_CH-1:0] rst,
   output logic              ready,
   output logic [2:0]        state
);

   localparam int CW = cnt_width(POR_CYCLES, LOCK_FILTER, STAGGER_CYCLES, NUM_CH);
   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CW-1:0] POR_LAST  = CW'(POR_CYCLES - 1);
   localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
   localparam logic [CW-1:0] LOCK_FULL = CW'(LOCK_FILTER);

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     cnt_lk;
   logic [IW-1:0]     idx_q, idx_d;
   logic [NUM_CH-1:0] rst_q, rst_d;
   logic              ready_q, ready_d;
   logic              lock_s, lock_ok, exit_req;

   sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_lock),
      .q     (lock_s)
   );

   // Only lock acquisition is filtered; loss acts on the raw synchronised level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt_lk <= '0;
      else if (!lock_s)          cnt_lk <= '0;
      else if (cnt_lk != LOCK_FULL) cnt_lk <= cnt_lk + CW'(1);
   end

   assign lock_ok  = (USE_LOCK == 0) || (cnt_lk == LOCK_FULL);
   assign exit_req = soft_rst_req || ((USE_LOCK != 0) && !lock_s);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      ready_d = ready_q;
      if ((state_q == WAIT_LOCK || state_q == RELEASE || state_q == RUN) && exit_req) begin
         state_d = ASSERT;
         cnt_d   = '0;
         idx_d   = '0;
         rst_d   = '1;
         ready_d = 1'b0;
      end else begin
         case (state_q)
            HOLD, ASSERT: begin
               if (state_q == ASSERT && soft_rst_req) begin
                  cnt_d = '0;
               end else if (cnt_q == POR_LAST) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            WAIT_LOCK: begin
               if (lock_ok) begin
                  rst_d[0] = 1'b0;
                  cnt_d    = '0;
                  idx_d    = '0;
                  if (NUM_CH == 1) begin
                     state_d = RUN;
                     ready_d = 1'b1;
                  end else begin
                     state_d = RELEASE;
                  end
               end
            end
            RELEASE: begin
               if (cnt_q == STAG_LAST) begin
                  cnt_d = '0;
                  idx_d = idx_q + IW'(1);
                  for (int k = 1; k < NUM_CH; k++) begin
                     if (k == int'(idx_q) + 1) rst_d[k] = 1'b0;
                  end
                  if (int'(idx_q) + 2 == NUM_CH) begin
                     state_d = RUN;
                     ready_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            RUN: begin
            end
            default: begin
               state_d = HOLD;
               cnt_d   = '0;
               rst_d   = '1;
               ready_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_q   <= '1;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
      end
   end

   assign rst   = rst_q;
   assign ready = ready_q;
   assign state = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - self-checking bench for rst_sequencer against a timeline-based reference model
module tb_rst_sequencer;

   localparam int NCH  = 3;
   localparam int POR  = 3;
   localparam int LF   = 4;
   localparam int STAG = 8;

   logic           clk, rst_n, pll_lock, soft_rst_req;
   logic [NCH-1:0] rst;
   logic           ready;
   logic [2:0]     state;
   logic [0:0]     rst1;
   logic           ready1;
   logic [2:0]     state1;
   logic           lock1, soft1;

   int errors = 0;
   int checks = 0;

   // Reference model: phase number (0..4), edge count since release, time rst[0] released.
   int m_n, m_mode, m_hold, m_rel, m_filt, m_ls1, m_ls2;

   rst_sequencer #(.NUM_CH(NCH), .POR_CYCLES(POR), .USE_LOCK(1),
                   .LOCK_FILTER(LF), .STAGGER_CYCLES(STAG)) u_dut (
      .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .soft_rst_req(soft_rst_req),
      .rst(rst), .ready(ready), .state(state)
   );

   rst_sequencer #(.NUM_CH(1), .POR_CYCLES(POR), .USE_LOCK(0),
                   .LOCK_FILTER(LF), .STAGGER_CYCLES(STAG)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .pll_lock(lock1), .soft_rst_req(soft1),
      .rst(rst1), .ready(ready1), .state(state1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, act, exp, m_n, $time);
      end
   endtask

   task automatic model_reset();
      m_n = 0; m_mode = 0; m_hold = 0; m_rel = -1000; m_filt = 0; m_ls1 = 0; m_ls2 = 0;
   endtask

   task automatic model_step();
      int  ls_pre;
      bit  lock_ok, leave;
      ls_pre  = m_ls2;
      lock_ok = (m_filt == LF);
      m_n++;
      m_filt = ls_pre ? ((m_filt + 1 > LF) ? LF : m_filt + 1) : 0;
      m_ls2  = m_ls1;
      m_ls1  = int'(pll_lock);
      leave  = (ls_pre == 0) || soft_rst_req;
      if (m_mode == 0 || m_mode == 4) begin
         if (m_mode == 4 && soft_rst_req) m_hold = 0;
         else begin
            m_hold++;
            if (m_hold == POR) m_mode = 1;
         end
      end else if (leave) begin
         m_mode = 4;
         m_hold = 0;
      end else if (m_mode == 1 && lock_ok) begin
         m_rel  = m_n;
         m_mode = 2;
      end else if (m_mode == 2 && m_n - m_rel == STAG * (NCH - 1)) begin
         m_mode = 3;
      end
   endtask

   function automatic int exp_rst();
      logic [NCH-1:0] r;
      r = '1;
      for (int k = 0; k < NCH; k++)
         if ((m_mode == 2 || m_mode == 3) && m_n >= m_rel + STAG * k) r[k] = 1'b0;
      return int'(r);
   endfunction

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("rst", int'(rst), exp_rst());
      chk("ready", int'(ready), int'(m_mode == 3));
      chk("state", int'(state), m_mode);
   endtask

   initial begin
      bit found;
      int run_left;
      rst_n = 1'b0; pll_lock = 1'b1; soft_rst_req = 1'b0; lock1 = 1'b0; soft1 = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_rst", int'(rst), 7);
      chk("reset_ready", int'(ready), 0);
      chk("reset_state", int'(state), 0);
      chk("reset_rst1", int'(rst1), 1);
      rst_n = 1'b1;

      // Lock held from the start: hold, filter, then 8-edge stagger.
      repeat (30) begin
         cycle();
         if (m_n == 3)  begin chk("a_state3", int'(state), 1); chk("a_rst1_e3", int'(rst1), 1); end
         if (m_n == 4)  begin chk("a_rst1_e4", int'(rst1), 0); chk("a_ready1_e4", int'(ready1), 1); end
         if (m_n == 6)  chk("a_rst_e6", int'(rst), 7);
         if (m_n == 7)  chk("a_rst_e7", int'(rst), 6);
         if (m_n == 15) chk("a_rst_e15", int'(rst), 4);
         if (m_n == 23) begin chk("a_rst_e23", int'(rst), 0); chk("a_ready_e23", int'(ready), 1); end
      end

      // Lock loss in RUN reaches the outputs two edges after the drop.
      pll_lock = 1'b0;
      cycle(); chk("b_loss_e0", int'(rst), 0);
      cycle(); chk("b_loss_e1", int'(ready), 1);
      cycle(); chk("b_loss_e2", int'(rst), 7); chk("b_loss_ready", int'(ready), 0);
      repeat (5) cycle();
      pll_lock = 1'b1;
      repeat (50) cycle();
      chk("b_rerun_rst", int'(rst), 0);
      chk("b_rerun_ready", int'(ready), 1);

      // Short lock glitch must not release; sustained lock must.
      pll_lock = 1'b0;
      repeat (20) cycle();
      pll_lock = 1'b1;
      repeat (3) begin cycle(); chk("c_glitch_hi", int'(rst), 7); end
      pll_lock = 1'b0;
      repeat (10) begin cycle(); chk("c_glitch_lo", int'(rst), 7); end
      pll_lock = 1'b1;
      found = 1'b0;
      repeat (40) begin
         cycle();
         if (rst[0] == 1'b0) found = 1'b1;
      end
      chk("c_release_seen", int'(found), 1);

      // Soft request mid-RELEASE, then a second one restarting the ASSERT count.
      soft_rst_req = 1'b1; cycle(); soft_rst_req = 1'b0;
      found = 1'b0;
      repeat (100) begin
         if (!found) begin
            cycle();
            if (m_mode == 2 && m_n == m_rel + 2) found = 1'b1;
         end
      end
      chk("d_in_release", int'(found), 1);
      soft_rst_req = 1'b1; cycle(); soft_rst_req = 1'b0;
      chk("d_pulse1_rst", int'(rst), 7);
      chk("d_pulse1_state", int'(state), 4);
      cycle();
      soft_rst_req = 1'b1; cycle(); soft_rst_req = 1'b0;
      chk("d_pulse2_state", int'(state), 4);
      cycle(); chk("d_p2_plus1", int'(state), 4);
      cycle(); chk("d_p2_plus2", int'(state), 4);
      cycle(); chk("d_p2_plus3", int'(state), 1);
      cycle(); chk("d_p2_plus4_rst", int'(rst), 6);

      // Randomised lock runs and sporadic soft requests.
      run_left = 0;
      repeat (600) begin
         if (run_left == 0) begin
            pll_lock = ($urandom_range(0, 3) != 0);
            run_left = int'($urandom_range(1, 40));
         end
         run_left--;
         soft_rst_req = ($urandom_range(0, 49) == 0);
         cycle();
      end
      soft_rst_req = 1'b0;

      // Asynchronous reset mid-run, observed without a clock edge.
      chk("f_ready1_before", int'(ready1), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("f_async_rst", int'(rst), 7);
      chk("f_async_ready", int'(ready), 0);
      chk("f_async_state", int'(state), 0);
      chk("f_async_rst1", int'(rst1), 1);
      chk("f_async_ready1", int'(ready1), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      pll_lock = 1'b1;
      repeat (30) cycle();
      chk("f_final_ready", int'(ready), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
